mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port, synchronous 8-bit x 256 memory unit. The memory has a registered read with 1-cycle latency and read-before-write on the same edge.
- Shares the memory between instruction fetch (port F) and load/store (port D) using round-robin fairness.
- Owns the memory's address, data_in and write lines; returns read data and an acknowledge to the winning requester.

Parameters:
- word_size, 8, data width of memory and both ports
- addr_size, 8, address width (2^addr_size words)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- f_req  input  1  fetch request; hold with f_we/f_addr/f_wdata stable until f_gnt
- f_we  input  1  fetch write enable (1 = write)
- f_addr  input  addr_size  fetch address
- f_wdata  input  word_size  fetch write data
- f_gnt  output  1  one-cycle pulse: fetch command issued to memory
- f_ack  output  1  one-cycle pulse: fetch access complete
- f_rdata  output  word_size  fetch read data, valid while f_ack=1 for reads
- d_req, d_we, d_addr, d_wdata, d_gnt, d_ack, d_rdata: same as f_* for the data port
- mem_address  output  addr_size  to memory address
- mem_data_in  output  word_size  to memory data_in
- mem_write  output  1  to memory write
- mem_data_out  input  word_size  from memory data_out (registered, 1-cycle latency)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all gnt/ack=0; mem_write=0; mem_address, mem_data_in, f_rdata, d_rdata = 0; last_grant=D, so F wins the first tie.
- Reset mid-operation: mem_write drops combinationally with rst_n, so no write occurs at the next edge. The in-flight access is discarded with no ack.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: at an edge with any req=1, arbitrate, latch the winner's {we, addr, wdata, id}, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (1 cycle): mem_address/mem_data_in = latched cmd; mem_write = latched we. Winner's gnt=1. Memory samples at the ending edge. Go to WAIT.
  - WAIT (1 cycle): mem_write=0. mem_data_out now valid. At the ending edge, capture mem_data_out into the winner's rdata register. Go to DONE.
  - DONE (1 cycle): winner's ack=1. On the data port the captured value is held until the next completed read on that port; writes leave rdata unchanged. Arbitrate at the ending edge exactly as in IDLE: go to ISSUE if any req=1, else go to IDLE.
- Arbitration:
  - Only one req high: that port wins.
  - Both high: the port other than last_grant wins.
  - last_grant updates at the arbitration edge.
- Latency: req sampled at edge E0 -> gnt in cycle E0..E1 -> ack in cycle E2..E3. A read returns the memory contents as of edge E1, including writes completed before E1.
- Throughput: back-to-back, one access per 3 cycles. Under continuous contention F and D strictly alternate.
- Requester rule: req still high in the cycle after gnt counts as a new request with the then-present command.
- mem_write is high only in ISSUE. mem_address/mem_data_in hold the last latched command outside ISSUE.
- gnt and ack are never high on both ports in the same cycle. Exactly one gnt and one ack are produced per access.
- Write ack: ack pulses; that port's rdata is unchanged.

Test Plan:
- Reset then idle: rst_n low 3 cycles, no req -> all outputs 0, mem_write never 1.
- Single write/read on D: write addr 0x3C data 0xA5, then read 0x3C -> d_gnt 1 cycle after req, d_ack 2 cycles after gnt, read returns d_rdata=0xA5 with d_ack; f_gnt/f_ack stay 0.
- Simultaneous requests after reset: F read 0x10 (preloaded 0x11) and D read 0x20 (preloaded 0x22) both high -> F granted first, f_rdata=0x11; D granted at F's DONE edge, d_rdata=0x22. Gnts are 3 cycles apart.
- Continuous contention: both req held high for 12 cycles -> grant order F, D, F, D. The ISSUE state appears every 3 cycles.
- Write-then-read ordering: D writes 0x7F to addr 0x05 while F holds a read of 0x05 pending -> D wins (last_grant=F from the prior test), then F read returns 0x7F.
- Reset mid-write: assert rst_n=0 during the ISSUE cycle of a write 0x55 to addr 0x08 (old value 0x00) -> mem_write drops immediately, no ack, and a later read of 0x08 returns 0x00.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the two-port memory arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the memory.
interface mem_port_arbiter_if #(
   parameter int word_size = 8,
   parameter int addr_size = 8
);
   logic                 f_req;
   logic                 f_we;
   logic [addr_size-1:0] f_addr;
   logic [word_size-1:0] f_wdata;
   logic                 f_gnt;
   logic                 f_ack;
   logic [word_size-1:0] f_rdata;

   logic                 d_req;
   logic                 d_we;
   logic [addr_size-1:0] d_addr;
   logic [word_size-1:0] d_wdata;
   logic                 d_gnt;
   logic                 d_ack;
   logic [word_size-1:0] d_rdata;

   logic [addr_size-1:0] mem_address;
   logic [word_size-1:0] mem_data_in;
   logic                 mem_write;
   logic [word_size-1:0] mem_data_out;

   modport slave (
      input  f_req, f_we, f_addr, f_wdata,
      output f_gnt, f_ack, f_rdata,
      input  d_req, d_we, d_addr, d_wdata,
      output d_gnt, d_ack, d_rdata,
      output mem_address, mem_data_in, mem_write,
      input  mem_data_out
   );

   modport master (
      output f_req, f_we, f_addr, f_wdata,
      input  f_gnt, f_ack, f_rdata,
      output d_req, d_we, d_addr, d_wdata,
      input  d_gnt, d_ack, d_rdata,
      input  mem_address, mem_data_in, mem_write,
      output mem_data_out
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one synchronous single-port memory between
// fetch (F) and load/store (D). One access every three cycles: ISSUE, WAIT, DONE.
module mem_port_arbiter #(
   parameter int word_size = 8,
   parameter int addr_size = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   mem_port_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t               state_q;
   logic                 winner_q;   // 1 = D; doubles as last_grant
   logic                 cmd_we_q;
   logic [addr_size-1:0] mem_address_q;
   logic [word_size-1:0] mem_data_in_q;
   logic                 mem_write_q;
   logic                 f_gnt_q, d_gnt_q, f_ack_q, d_ack_q;
   logic [word_size-1:0] f_rdata_q, d_rdata_q;

   logic                 any_req;
   logic                 winner_d;
   logic                 cmd_we_d;
   logic [addr_size-1:0] cmd_addr_d;
   logic [word_size-1:0] cmd_wdata_d;

   // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      any_req     = bus.f_req | bus.d_req;
      winner_d    = bus.d_req & (~bus.f_req | ~winner_q);
      cmd_we_d    = bus.f_we;
      cmd_addr_d  = bus.f_addr;
      cmd_wdata_d = bus.f_wdata;
      if (winner_d) begin
         cmd_we_d    = bus.d_we;
         cmd_addr_d  = bus.d_addr;
         cmd_wdata_d = bus.d_wdata;
      end
   end

   // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
   // The async clear also drops mem_write the moment rst_n falls, so an in-flight write never lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         winner_q      <= 1'b1;
         cmd_we_q      <= 1'b0;
         mem_address_q <= '0;
         mem_data_in_q <= '0;
         mem_write_q   <= 1'b0;
         f_gnt_q       <= 1'b0;
         d_gnt_q       <= 1'b0;
         f_ack_q       <= 1'b0;
         d_ack_q       <= 1'b0;
         f_rdata_q     <= '0;
         d_rdata_q     <= '0;
      end else begin
         mem_write_q <= 1'b0;
         f_gnt_q     <= 1'b0;
         d_gnt_q     <= 1'b0;
         f_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (any_req) begin
                  state_q       <= ISSUE;
                  winner_q      <= winner_d;
                  cmd_we_q      <= cmd_we_d;
                  mem_address_q <= cmd_addr_d;
                  mem_data_in_q <= cmd_wdata_d;
                  mem_write_q   <= cmd_we_d;
                  f_gnt_q       <= ~winner_d;
                  d_gnt_q       <= winner_d;
               end else begin
                  state_q <= IDLE;
               end
            end
            ISSUE: state_q <= WAIT;
            WAIT: begin
               state_q <= DONE;
               f_ack_q <= ~winner_q;
               d_ack_q <= winner_q;
               if (!cmd_we_q) begin
                  if (winner_q) d_rdata_q <= bus.mem_data_out;
                  else          f_rdata_q <= bus.mem_data_out;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.f_gnt       = f_gnt_q;
   assign bus.d_gnt       = d_gnt_q;
   assign bus.f_ack       = f_ack_q;
   assign bus.d_ack       = d_ack_q;
   assign bus.f_rdata     = f_rdata_q;
   assign bus.d_rdata     = d_rdata_q;
   assign bus.mem_address = mem_address_q;
   assign bus.mem_data_in = mem_data_in_q;
   assign bus.mem_write   = mem_write_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory, per-port command queues and a
// serialized-access reference model (round-robin order, data by access order).
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.word_size(8), .addr_size(8)) bus ();
   mem_port_arbiter #(.word_size(8), .addr_size(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   // Memory: registered read, read-before-write on the same edge.
   logic [7:0] mem [256] = '{default: 8'h00};
   always @(posedge clk) begin
      bus.mem_data_out <= mem[bus.mem_address];
      if (bus.mem_write) mem[bus.mem_address] <= bus.mem_data_in;
   end

   typedef struct packed { logic we; logic [7:0] addr; logic [7:0] wdata; } cmd_t;

   int         vectors = 0;
   int         miscompares = 0;
   cmd_t       f_q[$], d_q[$];
   logic [7:0] ref_mem [256] = '{default: 8'h00};
   logic [7:0] last_rd [2];
   cmd_t       pend;
   bit         pend_v = 1'b0;
   bit         pend_port;
   int         pend_cyc;
   bit         model_last = 1'b1;
   int         cyc = 0;
   bit         gnt_log[$];
   int         gnt_cyc_log[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_reqs();
      bus.f_req = (f_q.size() > 0);
      if (f_q.size() > 0) begin
         bus.f_we = f_q[0].we; bus.f_addr = f_q[0].addr; bus.f_wdata = f_q[0].wdata;
      end
      bus.d_req = (d_q.size() > 0);
      if (d_q.size() > 0) begin
         bus.d_we = d_q[0].we; bus.d_addr = d_q[0].addr; bus.d_wdata = d_q[0].wdata;
      end
   endtask

   // One clock: present queued commands, then check everything visible at the falling edge.
   task automatic cycle();
      bit         port;
      bit         exp_port;
      cmd_t       c;
      logic [7:0] obs_rd;
      drive_reqs();
      @(negedge clk);
      cyc++;
      chk("gnt_exclusive", {31'd0, !(bus.f_gnt && bus.d_gnt)}, 1);
      chk("ack_exclusive", {31'd0, !(bus.f_ack && bus.d_ack)}, 1);
      chk("write_only_with_gnt", {31'd0, !bus.mem_write || bus.f_gnt || bus.d_gnt}, 1);
      if (bus.f_gnt || bus.d_gnt) begin
         port = bus.d_gnt;
         exp_port = (bus.f_req && bus.d_req) ? !model_last : bus.d_req;
         chk("gnt_port", {31'd0, port}, {31'd0, exp_port});
         model_last = port;
         if ((port ? d_q.size() : f_q.size()) == 0) begin
            chk("gnt_without_req", 0, 1);
         end else begin
            c = port ? d_q.pop_front() : f_q.pop_front();
            chk("gnt_mem_address", {24'd0, bus.mem_address}, {24'd0, c.addr});
            chk("gnt_mem_write", {31'd0, bus.mem_write}, {31'd0, c.we});
            chk("gnt_mem_data_in", {24'd0, bus.mem_data_in}, {24'd0, c.wdata});
            chk("gnt_overlap", {31'd0, pend_v}, 0);
            pend = c; pend_v = 1'b1; pend_port = port; pend_cyc = cyc;
            gnt_log.push_back(port);
            gnt_cyc_log.push_back(cyc);
         end
      end
      if (bus.f_ack || bus.d_ack) begin
         port = bus.d_ack;
         chk("ack_pending", {31'd0, pend_v}, 1);
         if (pend_v) begin
            chk("ack_port", {31'd0, port}, {31'd0, pend_port});
            chk("ack_latency", cyc - pend_cyc, 2);
            if (pend.we) ref_mem[pend.addr] = pend.wdata;
            else         last_rd[port] = ref_mem[pend.addr];
            obs_rd = port ? bus.d_rdata : bus.f_rdata;
            chk("ack_rdata", {24'd0, obs_rd}, {24'd0, last_rd[port]});
            pend_v = 1'b0;
         end
      end else if (pend_v && (cyc - pend_cyc > 2)) begin
         chk("ack_missing", 0, 1);
         pend_v = 1'b0;
      end
   endtask

   task automatic drain(input int max_cyc);
      int n = 0;
      while ((f_q.size() > 0 || d_q.size() > 0 || pend_v) && n < max_cyc) begin
         cycle();
         n++;
      end
      chk("drain_timeout", {31'd0, n < max_cyc}, 1);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_f_gnt"}, {31'd0, bus.f_gnt}, 0);
      chk({tag, "_d_gnt"}, {31'd0, bus.d_gnt}, 0);
      chk({tag, "_f_ack"}, {31'd0, bus.f_ack}, 0);
      chk({tag, "_d_ack"}, {31'd0, bus.d_ack}, 0);
      chk({tag, "_mem_write"}, {31'd0, bus.mem_write}, 0);
      chk({tag, "_mem_address"}, {24'd0, bus.mem_address}, 0);
      chk({tag, "_mem_data_in"}, {24'd0, bus.mem_data_in}, 0);
      chk({tag, "_f_rdata"}, {24'd0, bus.f_rdata}, 0);
      chk({tag, "_d_rdata"}, {24'd0, bus.d_rdata}, 0);
   endtask

   task automatic clear_model();
      f_q.delete(); d_q.delete();
      pend_v = 1'b0; model_last = 1'b1;
      last_rd[0] = 8'h00; last_rd[1] = 8'h00;
   endtask

   task automatic apply_reset(input int n);
      rst_n = 1'b0;
      clear_model();
      #1;
      check_outputs_zero("reset");
      repeat (n) cycle();
      rst_n = 1'b1;
   endtask

   function automatic cmd_t mk(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
      cmd_t c;
      c.we = we; c.addr = addr; c.wdata = wdata;
      return c;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.f_req = 1'b0; bus.f_we = 1'b0; bus.f_addr = '0; bus.f_wdata = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      rst_n = 1'b0;
      clear_model();

      // Reset then idle
      apply_reset(3);
      repeat (4) cycle();
      check_outputs_zero("idle");

      // Single write then read on D
      d_q.push_back(mk(1'b1, 8'h3C, 8'hA5));
      cycle();
      chk("t2_d_gnt_latency", {31'd0, bus.d_gnt}, 1);
      chk("t2_f_gnt_quiet", {31'd0, bus.f_gnt}, 0);
      drain(20);
      d_q.push_back(mk(1'b0, 8'h3C, 8'h00));
      cycle();
      chk("t2_rd_d_gnt_latency", {31'd0, bus.d_gnt}, 1);
      drain(20);
      chk("t2_d_rdata", {24'd0, bus.d_rdata}, 32'hA5);

      // Preload through the DUT, then simultaneous requests after reset
      d_q.push_back(mk(1'b1, 8'h10, 8'h11));
      d_q.push_back(mk(1'b1, 8'h20, 8'h22));
      drain(30);
      apply_reset(2);
      gnt_log.delete(); gnt_cyc_log.delete();
      f_q.push_back(mk(1'b0, 8'h10, 8'h00));
      d_q.push_back(mk(1'b0, 8'h20, 8'h00));
      drain(30);
      chk("t3_gnt_count", gnt_log.size(), 2);
      if (gnt_log.size() == 2) begin
         chk("t3_first_is_f", {31'd0, gnt_log[0]}, 0);
         chk("t3_gnt_spacing", gnt_cyc_log[1] - gnt_cyc_log[0], 3);
      end
      chk("t3_f_rdata", {24'd0, bus.f_rdata}, 32'h11);
      chk("t3_d_rdata", {24'd0, bus.d_rdata}, 32'h22);

      // Continuous contention: strict alternation, one grant per 3 cycles
      gnt_log.delete(); gnt_cyc_log.delete();
      for (int i = 0; i < 4; i++) f_q.push_back(mk(1'b0, 8'($urandom_range(0, 63)), 8'h00));
      for (int i = 0; i < 3; i++) d_q.push_back(mk(1'b0, 8'($urandom_range(0, 63)), 8'h00));
      drain(60);
      chk("t4_gnt_count", gnt_log.size(), 7);
      for (int i = 0; i < gnt_log.size(); i++) begin
         chk("t4_alternate", {31'd0, gnt_log[i]}, i % 2);
         if (i > 0) chk("t4_spacing", gnt_cyc_log[i] - gnt_cyc_log[i-1], 3);
      end

      // Write-then-read ordering: last grant was F, so D goes first
      gnt_log.delete(); gnt_cyc_log.delete();
      d_q.push_back(mk(1'b1, 8'h05, 8'h7F));
      f_q.push_back(mk(1'b0, 8'h05, 8'h00));
      drain(30);
      chk("t5_gnt_count", gnt_log.size(), 2);
      if (gnt_log.size() == 2) chk("t5_d_first", {31'd0, gnt_log[0]}, 1);
      chk("t5_f_rdata", {24'd0, bus.f_rdata}, 32'h7F);

      // Reset during the ISSUE cycle of a write
      d_q.push_back(mk(1'b1, 8'h08, 8'h55));
      n = 0;
      do begin cycle(); n++; end while (!bus.d_gnt && n < 10);
      chk("t6_gnt_seen", {31'd0, bus.d_gnt}, 1);
      chk("t6_mem_write_before", {31'd0, bus.mem_write}, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_mem_write_drop", {31'd0, bus.mem_write}, 0);
      chk("t6_gnt_drop", {31'd0, bus.d_gnt}, 0);
      clear_model();
      repeat (2) cycle();
      rst_n = 1'b1;
      repeat (6) cycle();
      d_q.push_back(mk(1'b0, 8'h08, 8'h00));
      drain(20);
      chk("t6_read_old", {24'd0, bus.d_rdata}, 32'h00);

      // Randomized traffic on a small address window
      for (int i = 0; i < 400; i++) begin
         if (f_q.size() < 2 && $urandom_range(0, 2) == 0)
            f_q.push_back(mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom)));
         if (d_q.size() < 2 && $urandom_range(0, 2) == 0)
            d_q.push_back(mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom)));
         cycle();
      end
      drain(100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
